// File: rtl/riscv_memory_access.sv
// Memory-access stage: drives the req/ack data bus, holds execute while an access is in flight,
// and hands aligned/extended results or access faults to writeback through registered outputs.
module riscv_memory_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        count_instruction_in,
    input  logic        exception_in,
    input  logic [39:0] exception_context_in,
    input  logic [11:0] csr_addr_in,
    input  logic [1:0]  csr_write_in,
    input  logic [31:0] csr_data_in,
    input  logic        rd_write_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [31:0] rd_data_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_unsigned_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        count_instruction_out,
    output logic        exception_out,
    output logic [39:0] exception_context_out,
    output logic [11:0] csr_addr_out,
    output logic [1:0]  csr_write_out,
    output logic [31:0] csr_data_out,
    output logic        rd_write_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_data_out
);

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    store_be = 4'b0001 << a;
            2'd1:    store_be = 4'b0011 << {a[1], 1'b0};
            default: store_be = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    store_wdata = {4{d[7:0]}};
            2'd1:    store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [31:0] r, input logic [1:0] a,
                                             input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = r[{a, 3'b000} +: 8];
        h = r[{a[1], 4'b0000} +: 16];
        case (size)
            2'd0:    load_fmt = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    load_fmt = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_fmt = r;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;

    logic        lat_count_q, lat_exc_q, lat_rd_write_q, lat_read_q, lat_uns_q;
    logic [39:0] lat_ctx_q;
    logic [11:0] lat_csr_addr_q;
    logic [1:0]  lat_csr_write_q, lat_size_q;
    logic [31:0] lat_csr_data_q, lat_rd_data_q, lat_addr_q, lat_wdata_q;
    logic [4:0]  lat_rd_addr_q;

    logic        count_q, count_d, exc_q, exc_d, rd_write_q, rd_write_d;
    logic [39:0] ctx_q, ctx_d;
    logic [11:0] csr_addr_q, csr_addr_d;
    logic [1:0]  csr_write_q, csr_write_d;
    logic [31:0] csr_data_q, csr_data_d, rd_data_q, rd_data_d;
    logic [4:0]  rd_addr_q, rd_addr_d;

    logic mem_op, misaligned, start, timeout_hit;

    assign mem_op = mem_read_in | mem_write_in;

    always_comb begin
        case (mem_size_in)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = mem_addr_in[0];
            default: misaligned = |mem_addr_in[1:0];
        endcase
    end

    assign start       = (state_q == IDLE) && valid_in && mem_op && !exception_in && !misaligned;
    assign timeout_hit = (TIMEOUT_LIM != 32'd0) && (state_q == REQ) && !dmem_ack
                         && (cnt_q + 32'd1 == TIMEOUT_LIM);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_out   = 1'b0;
        count_d     = 1'b0;
        exc_d       = 1'b0;
        rd_write_d  = 1'b0;
        csr_write_d = 2'b0;
        ctx_d       = ctx_q;
        csr_addr_d  = csr_addr_q;
        csr_data_d  = csr_data_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        case (state_q)
            IDLE: begin
                cnt_d = 32'd0;
                if (valid_in && (exception_in || !mem_op || misaligned)) begin
                    count_d     = count_instruction_in;
                    exc_d       = exception_in;
                    ctx_d       = exception_context_in;
                    csr_addr_d  = csr_addr_in;
                    csr_write_d = csr_write_in;
                    csr_data_d  = csr_data_in;
                    rd_write_d  = rd_write_in;
                    rd_addr_d   = rd_addr_in;
                    rd_data_d   = rd_data_in;
                    if (!exception_in && mem_op) begin
                        exc_d      = 1'b1;
                        ctx_d      = {(mem_read_in ? 8'd4 : 8'd6), mem_addr_in};
                        rd_write_d = 1'b0;
                    end
                end else if (start) begin
                    state_d   = REQ;
                    stall_out = 1'b1;
                end
            end
            REQ: begin
                // Release upstream on the final cycle so the finished instruction is not reissued.
                stall_out = !dmem_ack && !timeout_hit;
                if (dmem_ack || timeout_hit) begin
                    state_d     = IDLE;
                    count_d     = lat_count_q;
                    exc_d       = lat_exc_q;
                    ctx_d       = lat_ctx_q;
                    csr_addr_d  = lat_csr_addr_q;
                    csr_write_d = lat_csr_write_q;
                    csr_data_d  = lat_csr_data_q;
                    rd_addr_d   = lat_rd_addr_q;
                    rd_data_d   = lat_rd_data_q;
                    rd_write_d  = lat_rd_write_q && lat_read_q;
                    if (dmem_ack) begin
                        if (lat_read_q)
                            rd_data_d = load_fmt(dmem_rdata, lat_addr_q[1:0], lat_size_q, lat_uns_q);
                    end else begin
                        exc_d      = 1'b1;
                        ctx_d      = {(lat_read_q ? 8'd5 : 8'd7), lat_addr_q};
                        rd_write_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 32'd0;
            count_q     <= 1'b0;
            exc_q       <= 1'b0;
            ctx_q       <= 40'd0;
            csr_addr_q  <= 12'd0;
            csr_write_q <= 2'd0;
            csr_data_q  <= 32'd0;
            rd_write_q  <= 1'b0;
            rd_addr_q   <= 5'd0;
            rd_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            exc_q       <= exc_d;
            ctx_q       <= ctx_d;
            csr_addr_q  <= csr_addr_d;
            csr_write_q <= csr_write_d;
            csr_data_q  <= csr_data_d;
            rd_write_q  <= rd_write_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Copy of the instruction that owns the bus; only meaningful while in REQ.
    always_ff @(posedge clk) begin
        if (start) begin
            lat_count_q     <= count_instruction_in;
            lat_exc_q       <= exception_in;
            lat_ctx_q       <= exception_context_in;
            lat_csr_addr_q  <= csr_addr_in;
            lat_csr_write_q <= csr_write_in;
            lat_csr_data_q  <= csr_data_in;
            lat_rd_write_q  <= rd_write_in;
            lat_rd_addr_q   <= rd_addr_in;
            lat_rd_data_q   <= rd_data_in;
            lat_read_q      <= mem_read_in;
            lat_size_q      <= mem_size_in;
            lat_uns_q       <= mem_unsigned_in;
            lat_addr_q      <= mem_addr_in;
            lat_wdata_q     <= mem_wdata_in;
        end
    end

    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = dmem_req && !lat_read_q;
    assign dmem_be    = dmem_req ? store_be(lat_size_q, lat_addr_q[1:0]) : 4'b0;
    assign dmem_addr  = dmem_req ? {lat_addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = dmem_req ? store_wdata(lat_size_q, lat_wdata_q) : 32'd0;

    assign count_instruction_out = count_q;
    assign exception_out         = exc_q;
    assign exception_context_out = ctx_q;
    assign csr_addr_out          = csr_addr_q;
    assign csr_write_out         = csr_write_q;
    assign csr_data_out          = csr_data_q;
    assign rd_write_out          = rd_write_q;
    assign rd_addr_out           = rd_addr_q;
    assign rd_data_out           = rd_data_q;

endmodule

// File: tb/tb_riscv_memory_access.sv
// Bench for riscv_memory_access: directed cases plus randomized instruction stream against a
// transaction-level reference model; the bench acts as both the upstream stage and the data bus.
module tb_riscv_memory_access;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, count_instruction_in, exception_in;
    logic [39:0] exception_context_in;
    logic [11:0] csr_addr_in;
    logic [1:0]  csr_write_in;
    logic [31:0] csr_data_in;
    logic        rd_write_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] rd_data_in;
    logic        mem_read_in, mem_write_in;
    logic [1:0]  mem_size_in;
    logic        mem_unsigned_in;
    logic [31:0] mem_addr_in, mem_wdata_in;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        count_instruction_out, exception_out;
    logic [39:0] exception_context_out;
    logic [11:0] csr_addr_out;
    logic [1:0]  csr_write_out;
    logic [31:0] csr_data_out;
    logic        rd_write_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_data_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        exc;
        logic [39:0] ctx;
        logic        tag;
        logic [11:0] csr_addr;
        logic [1:0]  csr_write;
        logic [31:0] csr_data;
        logic        rd_write;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } instr_t;

    riscv_memory_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .count_instruction_in(count_instruction_in), .exception_in(exception_in),
        .exception_context_in(exception_context_in), .csr_addr_in(csr_addr_in),
        .csr_write_in(csr_write_in), .csr_data_in(csr_data_in), .rd_write_in(rd_write_in),
        .rd_addr_in(rd_addr_in), .rd_data_in(rd_data_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
        .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in), .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .count_instruction_out(count_instruction_out), .exception_out(exception_out),
        .exception_context_out(exception_context_out), .csr_addr_out(csr_addr_out),
        .csr_write_out(csr_write_out), .csr_data_out(csr_data_out), .rd_write_out(rd_write_out),
        .rd_addr_out(rd_addr_out), .rd_data_out(rd_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] r, input logic [31:0] a,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (r >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (r >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'd0) return 4'(1 << (a % 4));
        if (size == 2'd1) return 4'(3 << ((a % 4) / 2 * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic instr_t rand_instr(input int kind);
        instr_t t;
        t.exc       = ($urandom_range(0, 7) == 0);
        t.ctx       = {8'($urandom), $urandom};
        t.tag       = 1'($urandom);
        t.csr_addr  = 12'($urandom);
        t.csr_write = 2'($urandom);
        t.csr_data  = $urandom;
        t.rd_write  = 1'($urandom);
        t.rd_addr   = 5'($urandom);
        t.rd_data   = $urandom;
        t.rd        = (kind == 1);
        t.wr        = (kind == 2);
        t.size      = 2'($urandom);
        t.uns       = 1'($urandom);
        t.addr      = $urandom;
        t.wdata     = $urandom;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        valid_in             = 1'b1;
        count_instruction_in = t.tag;
        exception_in         = t.exc;
        exception_context_in = t.ctx;
        csr_addr_in          = t.csr_addr;
        csr_write_in         = t.csr_write;
        csr_data_in          = t.csr_data;
        rd_write_in          = t.rd_write;
        rd_addr_in           = t.rd_addr;
        rd_data_in           = t.rd_data;
        mem_read_in          = t.rd;
        mem_write_in         = t.wr;
        mem_size_in          = t.size;
        mem_unsigned_in      = t.uns;
        mem_addr_in          = t.addr;
        mem_wdata_in         = t.wdata;
    endtask

    // Presents one instruction (called at a negedge), plays the bus with an ack after 'delay'
    // wait cycles, and checks the writeback fields on the cycle the instruction retires.
    task automatic run_instr(input instr_t t, input int delay, input logic [31:0] rdata);
        bit          is_mem, mis, access, ack_now, tmo, timed_out;
        int          nreq;
        logic        e_exc, e_rdw;
        logic [39:0] e_ctx;
        logic [31:0] e_data;
        is_mem = t.rd || t.wr;
        if (t.size == 2'd0)      mis = 0;
        else if (t.size == 2'd1) mis = (t.addr % 2) != 0;
        else                     mis = (t.addr % 4) != 0;
        access    = is_mem && !t.exc && !mis;
        timed_out = access && (delay >= TMO);
        drive(t);
        dmem_ack = 1'b0;
        #1;
        chk("stall_first", stall_out, access);
        chk("req_first", dmem_req, 0);
        nreq = 0;
        if (access) begin
            for (int k = 1; k <= TMO + 1; k++) begin
                @(posedge clk);
                @(negedge clk);
                ack_now    = (k == delay + 1);
                dmem_ack   = ack_now;
                dmem_rdata = ack_now ? rdata : $urandom;
                #1;
                nreq++;
                tmo = !ack_now && (k == TMO);
                chk("req_hold", dmem_req, 1);
                chk("dmem_addr", dmem_addr, t.addr & 32'hFFFF_FFFC);
                chk("dmem_we", dmem_we, t.wr);
                if (t.wr) begin
                    chk("dmem_be", dmem_be, ref_be(t.size, t.addr));
                    chk("dmem_wdata", dmem_wdata, ref_wdata(t.size, t.wdata));
                end
                chk("stall_req", stall_out, !(ack_now || tmo));
                if (ack_now || tmo) break;
            end
            chk("req_cycles", nreq, timed_out ? TMO : delay + 1);
        end
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        e_exc  = t.exc;
        e_ctx  = t.ctx;
        e_rdw  = t.rd_write;
        e_data = t.rd_data;
        if (!t.exc && is_mem) begin
            e_rdw = t.rd_write && t.rd;
            if (mis) begin
                e_exc = 1; e_rdw = 0;
                e_ctx = {(t.rd ? 8'd4 : 8'd6), t.addr};
            end else if (timed_out) begin
                e_exc = 1; e_rdw = 0;
                e_ctx = {(t.rd ? 8'd5 : 8'd7), t.addr};
            end else if (t.rd) begin
                e_data = ref_load(rdata, t.addr, t.size, t.uns);
            end
        end
        chk("req_after", dmem_req, 0);
        chk("exc_out", exception_out, e_exc);
        if (e_exc) chk("ctx_out", exception_context_out, e_ctx);
        chk("rd_write_out", rd_write_out, e_rdw);
        if (e_rdw) begin
            chk("rd_addr_out", rd_addr_out, t.rd_addr);
            chk("rd_data_out", rd_data_out, e_data);
        end
        chk("count_out", count_instruction_out, t.tag);
        chk("csr_write_out", csr_write_out, t.csr_write);
        chk("csr_addr_out", csr_addr_out, t.csr_addr);
        chk("csr_data_out", csr_data_out, t.csr_data);
    endtask

    task automatic run_bubble();
        instr_t t;
        t = rand_instr(int'($urandom_range(0, 2)));
        drive(t);
        valid_in = 1'b0;
        #1;
        chk("bubble_stall", stall_out, 0);
        chk("bubble_req", dmem_req, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("bubble_rdw", rd_write_out, 0);
        chk("bubble_exc", exception_out, 0);
        chk("bubble_cnt", count_instruction_out, 0);
        chk("bubble_csrw", csr_write_out, 0);
    endtask

    initial begin
        instr_t t;
        reset = 1'b1;
        valid_in = 0; count_instruction_in = 0; exception_in = 0; exception_context_in = '0;
        csr_addr_in = '0; csr_write_in = '0; csr_data_in = '0; rd_write_in = 0; rd_addr_in = '0;
        rd_data_in = '0; mem_read_in = 0; mem_write_in = 0; mem_size_in = '0; mem_unsigned_in = 0;
        mem_addr_in = '0; mem_wdata_in = '0; dmem_ack = 0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", stall_out, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_rdw", rd_write_out, 0);
        chk("rst_exc", exception_out, 0);
        chk("rst_cnt", count_instruction_out, 0);
        chk("rst_csrw", csr_write_out, 0);
        chk("rst_rd_data", rd_data_out, 0);
        chk("rst_ctx", exception_context_out, 0);
        reset = 1'b0;

        // ALU op: rd=5, data 0x1234
        t = rand_instr(0); t.exc = 0; t.rd_write = 1; t.rd_addr = 5; t.rd_data = 32'h1234;
        run_instr(t, 0, 0);
        // LB from 0x103, byte 0x80 sign-extends
        t = rand_instr(1); t.exc = 0; t.rd_write = 1; t.size = 0; t.uns = 0; t.addr = 32'h103;
        run_instr(t, 3, 32'h80FF_0000);
        // LBU of the same byte zero-extends
        t.uns = 1;
        run_instr(t, 0, 32'h80FF_0000);
        // SH to 0x202
        t = rand_instr(2); t.exc = 0; t.size = 1; t.addr = 32'h202; t.wdata = 32'h0000_ABCD;
        run_instr(t, 1, 0);
        // misaligned LW and SW
        t = rand_instr(1); t.exc = 0; t.size = 2; t.addr = 32'h101;
        run_instr(t, 0, 0);
        t = rand_instr(2); t.exc = 0; t.size = 3; t.addr = 32'h102;
        run_instr(t, 0, 0);
        // store never acked times out; ack on the timeout cycle wins
        t = rand_instr(2); t.exc = 0; t.size = 2; t.addr = 32'h400;
        run_instr(t, 99, 0);
        t = rand_instr(1); t.exc = 0; t.rd_write = 1; t.size = 1; t.uns = 0; t.addr = 32'h402;
        run_instr(t, TMO - 1, 32'h8001_7FFF);
        run_bubble();

        // reset while a load is outstanding: no writeback of it
        t = rand_instr(1); t.exc = 0; t.rd_write = 1; t.size = 2; t.addr = 32'h500;
        drive(t);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rstreq_req", dmem_req, 1);
        reset = 1'b1;
        valid_in = 1'b0;
        dmem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk("rstreq_req_drop", dmem_req, 0);
        chk("rstreq_stall", stall_out, 0);
        chk("rstreq_rdw", rd_write_out, 0);
        chk("rstreq_exc", exception_out, 0);
        chk("rstreq_cnt", count_instruction_out, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rstreq_no_wb", rd_write_out, 0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                run_bubble();
            end else begin
                t = rand_instr(int'($urandom_range(0, 2)));
                if ($urandom_range(0, 1) == 1) t.addr = t.addr & ~(32'h3 >> (2 - 32'(t.size == 0 ? 2 : (t.size == 1 ? 1 : 0))));
                run_instr(t, int'($urandom_range(0, TMO + 1)), $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
